fetch_unit: RTL and testbench

Instruction fetch stage that produces the PC/instruction pair written into the IF/ID pipeline register. It owns the architectural fetch PC, issues requests to the instruction memory port over a valid/ready handshake, and keeps one instruction in flight. It buffers returned instructions while IF/ID is stalled, and kills in-flight fetches on a redirect so that no wrong-path instruction reaches decode.

---
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID pipeline register.
// Owns the fetch PC, keeps at most one imem request in flight, parks one
// returned instruction while IF/ID is stalled, and drops any response that
// belongs to a fetch killed by a redirect.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   REQ   | presenting a request at r_pc, waiting for imem_req_ready
//   WAIT  | one request outstanding, waiting for its response
//   HOLD  | response parked in the buffer, slot still occupied by a stalled
//         | instruction; no new request until the slot is consumed
//   DRAIN | a killed request is still outstanding; its response is dropped
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_pc;
    logic [63:0] r_inflight_pc;

    logic        r_out_valid;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_inst;

    logic        r_buf_valid;
    logic [63:0] r_buf_pc;
    logic [31:0] r_buf_inst;

    logic        w_consume;
    logic        w_slot_free;
    logic        w_handshake;
    logic        w_resp_to_slot;
    logic        w_resp_to_buf;
    logic        w_buf_to_slot;
    logic [63:0] w_redirect_pc_al;

    // Slot is consumed by IF/ID only when nothing holds it and no flush kills it.
    assign w_consume        = r_out_valid && !stall && !redirect;
    assign w_slot_free      = !r_out_valid || w_consume;

    // Request is withdrawn combinationally on redirect and while in reset.
    assign imem_req_valid   = (r_state == S_REQ) && !redirect && !rst;
    assign imem_req_addr    = r_pc;
    assign w_handshake      = imem_req_valid && imem_req_ready;

    // Data-movement events; all of them are suppressed by a redirect.
    assign w_resp_to_slot   = !redirect && (r_state == S_WAIT) && imem_resp_valid && w_slot_free;
    assign w_resp_to_buf    = !redirect && (r_state == S_WAIT) && imem_resp_valid && !w_slot_free;
    assign w_buf_to_slot    = !redirect && (r_state == S_HOLD) && w_consume;

    assign w_redirect_pc_al = {redirect_pc[63:2], 2'b00};

    assign if_valid         = r_out_valid;
    assign if_pc            = r_out_pc;
    assign if_inst          = r_out_inst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect dominates stall and response.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            // An outstanding request whose response has not shown up yet must be drained.
            if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_resp_valid) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_handshake) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        w_state_nxt = w_slot_free ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    // Fetch PC: reset vector, redirect target, or advance by one word on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= w_redirect_pc_al;
        end else if (w_handshake) begin
            r_pc <= r_pc + 64'd4;
        end
    end

    // Remember the address of the outstanding request so its response can be tagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight_pc <= '0;
        end else if (w_handshake) begin
            r_inflight_pc <= r_pc;
        end
    end

    // Output slot driving IF/ID.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
        end else if (w_resp_to_slot) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_inflight_pc;
            r_out_inst  <= imem_resp_data;
        end else if (w_buf_to_slot) begin
            r_out_valid <= r_buf_valid;
            r_out_pc    <= r_buf_pc;
            r_out_inst  <= r_buf_inst;
        end else if (w_consume) begin
            // Consumed with nothing to replace it; pc/inst keep their last value.
            r_out_valid <= 1'b0;
        end
    end

    // One-entry buffer catching a response that arrives while the slot is stalled.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_buf_valid <= 1'b0;
            r_buf_pc    <= '0;
            r_buf_inst  <= '0;
        end else if (w_resp_to_buf) begin
            r_buf_valid <= 1'b1;
            r_buf_pc    <= r_inflight_pc;
            r_buf_inst  <= imem_resp_data;
        end else if (w_buf_to_slot) begin
            r_buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the main fetch/stall/back-pressure
// flow, plus hand-written sequences for redirect corner cases.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(64'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory model returns for a given address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Memory model: one response, mem_lat cycles after the accepting cycle.
    int          mem_lat = 1;
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_addr;
    always @(posedge clk) begin
        if (rst) begin
            m_busy          <= 1'b0;
            m_cnt           <= 0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            imem_resp_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(m_addr);
                    m_busy          <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_word(imem_req_addr);
                end else begin
                    m_busy <= 1'b1;
                    m_cnt  <= mem_lat - 1;
                    m_addr <= imem_req_addr;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        mem_lat        = lat;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("req_valid_in_reset", {63'd0, imem_req_valid}, 64'd0);
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request handshake; n = cycles waited, ifv = cycles with if_valid seen meanwhile.
    task automatic wait_hs(input logic [63:0] exp_addr, input string name, output int n, output int ifv);
        bit found;
        found = 1'b0;
        n     = 0;
        ifv   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                break;
            end
            if (if_valid) ifv++;
            n++;
            tick();
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: no handshake within bound, expected addr %h", name, exp_addr);
        end else begin
            chk(name, imem_req_addr, exp_addr);
            tick();
        end
    endtask

    // Waits (bounded) for the first presented instruction and checks it.
    task automatic wait_ifv(input logic [63:0] exp_pc, input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: if_valid never rose, expected pc %h", name, exp_pc);
        end else begin
            chk({name, "_pc"}, if_pc, exp_pc);
            chk({name, "_inst"}, {32'd0, if_inst}, {32'd0, mem_word(exp_pc)});
            tick();
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [63:0] rdpc;
        logic        ready;
        logic        exp_rv;
        logic [63:0] exp_ra;
        logic        exp_iv;
        logic        chk_pc;
        logic [63:0] exp_pc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        int n;
        int ifv;
        logic [31:0] exp_inst;

        // Cycle-by-cycle trace from reset release, 1-cycle memory latency.
        //            stall redir rdpc                   rdy  rv   ra                     iv   chk  pc
        vecs[0]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_0004, 1'b1, 1'b1, 64'h0000_0000_8000_0000};
        vecs[3]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 64'h0};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_0008, 1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[7]  = '{1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[8]  = '{1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[9]  = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_8000_0004};
        vecs[10] = '{1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'h0000_0000_8000_000C, 1'b1, 1'b1, 64'h0000_0000_8000_0008};
        vecs[11] = '{1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'h0000_0000_8000_000C, 1'b0, 1'b0, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'h0000_0000_8000_000C, 1'b0, 1'b0, 64'h0};
        vecs[13] = '{1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'h0000_0000_8000_000C, 1'b0, 1'b0, 64'h0};
        vecs[14] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_000C, 1'b0, 1'b0, 64'h0};
        vecs[15] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 64'h0};
        vecs[16] = '{1'b0, 1'b1, 64'h0000_0000_8000_1002, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_000C};
        vecs[17] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_1000, 1'b0, 1'b1, 64'h0};
        vecs[18] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 64'h0};
        vecs[19] = '{1'b0, 1'b0, 64'h0,                 1'b1, 1'b1, 64'h0000_0000_8000_1004, 1'b1, 1'b1, 64'h0000_0000_8000_1000};

        do_reset(1);
        for (int i = 0; i < NV; i++) begin
            stall          = vecs[i].stall;
            redirect       = vecs[i].redirect;
            redirect_pc    = vecs[i].rdpc;
            imem_req_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) begin
                chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].exp_ra);
            end
            chk($sformatf("v%0d_if_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].exp_iv});
            if (vecs[i].chk_pc) begin
                exp_inst = vecs[i].exp_iv ? mem_word(vecs[i].exp_pc) : 32'd0;
                chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_if_inst", i), {32'd0, if_inst}, {32'd0, exp_inst});
            end
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;

        // Redirect one cycle after a handshake, 3-cycle memory: the killed response must be drained.
        do_reset(3);
        wait_hs(64'h0000_0000_8000_0000, "rw_hs0", n, ifv);
        wait_hs(64'h0000_0000_8000_0004, "rw_hs1", n, ifv);
        wait_hs(64'h0000_0000_8000_0008, "rw_hs2", n, ifv);
        redirect    = 1'b1;
        redirect_pc = 64'h0000_0000_8000_1002;
        @(negedge clk);
        chk("rw_req_gated", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect = 1'b0;
        wait_hs(64'h0000_0000_8000_1000, "rw_new_addr", n, ifv);
        chk("rw_drain_cycles", n, 64'd2);
        chk("rw_no_if_valid", ifv, 64'd0);
        wait_ifv(64'h0000_0000_8000_1000, "rw_first");

        // Redirect, stall and response in the same cycle.
        do_reset(1);
        tick();
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("co_slot_pc", if_pc, 64'h0000_0000_8000_0000);
        chk("co_hs_addr", imem_req_addr, 64'h0000_0000_8000_0004);
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h0000_0000_8000_2003;
        @(negedge clk);
        chk("co_resp_present", {63'd0, imem_resp_valid}, 64'd1);
        chk("co_req_gated", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        chk("co_if_valid", {63'd0, if_valid}, 64'd0);
        chk("co_if_pc_clr", if_pc, 64'd0);
        chk("co_if_inst_clr", {32'd0, if_inst}, 64'd0);
        chk("co_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("co_req_addr", imem_req_addr, 64'h0000_0000_8000_2000);
        tick();
        @(negedge clk);
        chk("co_if_valid_gap", {63'd0, if_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("co_new_if_valid", {63'd0, if_valid}, 64'd1);
        chk("co_new_if_pc", if_pc, 64'h0000_0000_8000_2000);
        tick();

        // PC wrap at the top of the address space.
        do_reset(1);
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk("wr_req_gated", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("wr_req_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        @(negedge clk);
        chk("wr_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_if_inst", {32'd0, if_inst}, {32'd0, mem_word(64'hFFFF_FFFF_FFFF_FFFC)});
        chk("wr_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("wr_req_wrap", imem_req_addr, 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
